// File: rtl/decoder_pkg.sv
// Shared decoder types and sizing used by the uart transmit path.
package decoder_pkg;

  localparam int unsigned WordWidth     = 32;
  localparam int unsigned UartFifoDepth = 8;

  typedef logic [WordWidth-1:0] word_t;

endpackage : decoder_pkg

// File: rtl/uart_tx_fifo.sv
// Word-wide transmit FIFO feeding the uart. The head word is shown ahead on
// d_out while rts is high; the uart pops it with next. Fill level and sticky
// overflow/underflow flags are exposed for software status polling.
module uart_tx_fifo
  import decoder_pkg::*;
#(
  parameter int unsigned Depth = UartFifoDepth,
  parameter int unsigned Width = WordWidth
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     wr_en,
  input  logic [Width-1:0]         wr_data,
  input  logic                     clr,
  input  logic                     err_clr,
  output logic [Width-1:0]         d_out,
  output logic                     rts,
  input  logic                     next,
  output logic                     full,
  output logic [$clog2(Depth):0]   level,
  output logic                     overflow,
  underflow
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthCount = CW'(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;

  logic pop;
  logic push;
  logic push_blocked;
  logic pop_empty;

  // Handshake qualification: a pop needs a valid head, a push needs room
  // unless the same cycle frees an entry.
  always_comb begin
    pop          = next && (count != '0);
    push         = wr_en && ((count != DepthCount) || pop);
    push_blocked = wr_en && (count == DepthCount) && !pop;
    pop_empty    = next && (count == '0);
  end

  // Storage, pointers, occupancy and sticky error flags.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      // A new error event in the same cycle as err_clr keeps the flag set.
      if (push_blocked) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (pop_empty) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end

  // Status and show-ahead head word, all derived from registered state.
  always_comb begin
    d_out = mem[rd_ptr];
    rts   = (count != '0);
    full  = (count == DepthCount);
    level = count;
  end

endmodule : uart_tx_fifo
